// File: rtl/fetch_unit_pkg.sv
// fetch_pkg: default widths and FSM state type shared by the fetch stage
package fetch_pkg;
  localparam int PC_W = 10;
  localparam int INSTR_W = 9;
  localparam int LUT_IDX_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_if: instruction memory bus plus decoder-facing instruction stream
interface fetch_if #(
  parameter int PC_W = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
);
  logic [PC_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0] instr_pc;
  logic instr_valid;
  modport master (output imem_addr, instr_out, instr_pc, instr_valid, input imem_rdata);
  modport slave (input imem_addr, instr_out, instr_pc, instr_valid, output imem_rdata);
endinterface

// File: rtl/fetch_unit_jump_lut.sv
// jump_lut: programmable branch-target table, one write port, combinational read (old data on same-index write)
module jump_lut #(
  parameter int IDX_W = fetch_pkg::LUT_IDX_W,
  parameter int W = fetch_pkg::PC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);
  logic [2**IDX_W-1:0][W-1:0] mem_q, mem_d;
  // Next table contents: a single entry replaced on write
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  // Table storage, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else mem_q <= mem_d;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch stage with 1-cycle imem, stall, halt and LUT branches; FETCH_PERF_CNT_EN adds perf counters
module fetch_unit #(
  parameter int PC_W = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int LUT_IDX_W = fetch_pkg::LUT_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt_in,
  input  logic                 branch_taken,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  fetch_if.master              bus,
  output logic                 done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]          perf_instr_cnt,
  output logic [15:0]          perf_bubble_cnt
`endif
);
  import fetch_pkg::*;
  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, cur_pc_q, cur_pc_d, lut_rdata;
  logic valid_q, valid_d, done_q, done_d;
  logic run, go, accept, taken;
  jump_lut #(.IDX_W(LUT_IDX_W), .W(PC_W)) u_lut (
    .clk(clk), .rst_n(rst_n), .we(lut_we), .waddr(lut_waddr), .wdata(lut_wdata),
    .raddr(branch_idx), .rdata(lut_rdata)
  );
  assign run = state_q == RUN;
  assign go = start && !run;
  assign accept = run && valid_q && !stall;
  assign taken = accept && branch_taken;
  // Next state: launch, halt acceptance, or advance (a taken branch squashes the pc+1 fetch)
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cur_pc_d = cur_pc_q;
    valid_d = valid_q;
    done_d = done_q;
    if (go) begin
      state_d = RUN;
      pc_d = '0;
      cur_pc_d = '0;
      valid_d = 1'b0;
      done_d = 1'b0;
    end else if (accept && halt_in) begin
      state_d = DONE;
      valid_d = 1'b0;
      done_d = 1'b1;
    end else if (run && !stall) begin
      cur_pc_d = pc_q;
      pc_d = taken ? lut_rdata : pc_q + 1'b1;
      valid_d = !taken;
    end
  end
  // FSM and fetch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      cur_pc_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cur_pc_q <= cur_pc_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
  assign bus.imem_addr = (run && stall) ? cur_pc_q : pc_q;
  assign bus.instr_out = bus.imem_rdata;
  assign bus.instr_pc = cur_pc_q;
  assign bus.instr_valid = valid_q && run;
  assign done = done_q;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] icnt_q, icnt_d, bcnt_q, bcnt_d;
  // Saturating counters; the launch cycle itself is the first startup bubble
  always_comb begin
    icnt_d = go ? 16'd0 : (accept && icnt_q != 16'hFFFF) ? icnt_q + 16'd1 : icnt_q;
    bcnt_d = go ? 16'd1 : (run && !valid_q && bcnt_q != 16'hFFFF) ? bcnt_q + 16'd1 : bcnt_q;
  end
  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
      bcnt_q <= bcnt_d;
    end
  end
  assign perf_instr_cnt = icnt_q;
  assign perf_bubble_cnt = bcnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven check of fetch_unit plus wrap and async-reset sequences
module tb_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stall = 1'b0, halt_in = 1'b0, branch_taken = 1'b0, lut_we = 1'b0;
  logic [3:0] branch_idx = '0, lut_waddr = '0;
  logic [9:0] lut_wdata = '0;
  logic done, start2 = 1'b0, done2;
  int total = 0, bad = 0;
  fetch_if bus ();
  fetch_if #(.PC_W(4)) bus2 ();
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] pic, pbc, pic2, pbc2;
`endif
  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt_in(halt_in),
    .branch_taken(branch_taken), .branch_idx(branch_idx), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .bus(bus.master), .done(done)
`ifdef FETCH_PERF_CNT_EN
    , .perf_instr_cnt(pic), .perf_bubble_cnt(pbc)
`endif
  );
  fetch_unit #(.PC_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .stall(1'b0), .halt_in(1'b0),
    .branch_taken(1'b0), .branch_idx(4'd0), .lut_we(1'b0),
    .lut_waddr(4'd0), .lut_wdata(4'd0), .bus(bus2.master), .done(done2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_instr_cnt(pic2), .perf_bubble_cnt(pbc2)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.imem_rdata <= 9'(bus.imem_addr);
    bus2.imem_rdata <= 9'(bus2.imem_addr);
  end
  typedef struct packed {
    logic st, sl, br, hl, we;
    logic [3:0] idx;
    logic [9:0] wd;
    logic ev;
    logic [9:0] epc, eaddr;
    logic ed;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t V(input logic st, sl, br, hl, we, input int idx, wd,
                             input logic ev, input int epc, eaddr, input logic ed);
    V = '{st, sl, br, hl, we, 4'(idx), 10'(wd), ev, 10'(epc), 10'(eaddr), ed};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    start = v.st; stall = v.sl; branch_taken = v.br; halt_in = v.hl; lut_we = v.we;
    branch_idx = v.idx; lut_waddr = v.idx; lut_wdata = v.wd;
    @(negedge clk);
  endtask
  initial begin
    bit found;
    tbl.push_back(V(0,0,0,0,1,3,'h40, 0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 1,0,1,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 1,1,2,0));
    tbl.push_back(V(1,0,0,0,0,0,0, 1,2,3,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 1,3,4,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 1,4,5,0));
    tbl.push_back(V(0,1,0,0,0,0,0, 1,5,5,0));
    tbl.push_back(V(0,1,1,0,0,3,0, 1,5,5,0));
    tbl.push_back(V(0,1,0,0,0,0,0, 1,5,5,0));
    for (int p = 5; p < 10; p++) tbl.push_back(V(0,0,0,0,0,0,0, 1,p,p+1,0));
    tbl.push_back(V(0,0,1,0,1,3,'h50, 1,10,11,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 0,0,'h40,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 1,'h40,'h41,0));
    tbl.push_back(V(0,0,1,0,0,3,0, 1,'h41,'h42,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 0,0,'h50,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 1,'h50,'h51,0));
    tbl.push_back(V(0,0,0,1,0,0,0, 1,'h51,'h52,0));
    tbl.push_back(V(0,1,1,1,0,3,0, 0,0,'h52,1));
    tbl.push_back(V(1,0,0,0,0,0,0, 0,0,'h52,1));
    tbl.push_back(V(0,0,0,0,0,0,0, 0,0,0,0));
    for (int p = 0; p < 7; p++) tbl.push_back(V(0,0,0,0,0,0,0, 1,p,p+1,0));
    tbl.push_back(V(0,0,1,1,0,3,0, 1,7,8,0));
    tbl.push_back(V(0,0,0,0,0,0,0, 0,0,8,1));
    tbl.push_back(V(0,0,0,0,0,0,0, 0,0,8,1));
    #12;
    chk("rst valid", 32'(bus.instr_valid), 0);
    chk("rst pc", 32'(bus.instr_pc), 0);
    chk("rst addr", 32'(bus.imem_addr), 0);
    chk("rst done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      chk($sformatf("row%0d valid", i), 32'(bus.instr_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d addr", i), 32'(bus.imem_addr), 32'(tbl[i].eaddr));
      chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].ed));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d pc", i), 32'(bus.instr_pc), 32'(tbl[i].epc));
        chk($sformatf("row%0d instr", i), 32'(bus.instr_out), 32'(tbl[i].epc));
      end
    end
    apply(V(0,0,0,0,0,0,0, 0,0,0,0));
`ifdef FETCH_PERF_CNT_EN
    chk("perf instr", 32'(pic), 8);
    chk("perf bubble", 32'(pbc), 2);
`endif
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      found = bus2.instr_valid && bus2.instr_pc == 4'd15;
    end
    chk("wrap seen15", 32'(found), 1);
    @(negedge clk);
    chk("wrap valid", 32'(bus2.instr_valid), 1);
    chk("wrap pc", 32'(bus2.instr_pc), 0);
    chk("wrap instr", 32'(bus2.instr_out), 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-rst valid", 32'(bus.instr_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(bus.instr_valid), 0);
    chk("arst pc", 32'(bus.instr_pc), 0);
    chk("arst addr", 32'(bus.imem_addr), 0);
    chk("arst done", 32'(done), 0);
    chk("arst wrap valid", 32'(bus2.instr_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d valid", c), 32'(bus.instr_valid), 0);
      chk($sformatf("idle%0d addr", c), 32'(bus.imem_addr), 0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("arst perf instr", 32'(pic), 0);
    chk("arst perf bubble", 32'(pbc), 0);
`endif
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 branch_taken = 1'b1; branch_idx = 4'd3;
    @(negedge clk);
    chk("lut0 br valid", 32'(bus.instr_valid), 1);
    chk("lut0 br pc", 32'(bus.instr_pc), 0);
    @(posedge clk); #1 branch_taken = 1'b0;
    @(negedge clk);
    chk("lut0 bubble", 32'(bus.instr_valid), 0);
    chk("lut0 target addr", 32'(bus.imem_addr), 0);
    @(negedge clk);
    chk("lut0 tgt valid", 32'(bus.instr_valid), 1);
    chk("lut0 tgt pc", 32'(bus.instr_pc), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and drives a synchronous instruction memory with 1-cycle read latency.
- Presents one 9-bit instruction per cycle to the decoder, along with its PC and a valid flag.
- Redirects the PC on taken branches via a 16-entry programmable jump-target LUT, indexed by the 4-bit branch immediate. Handles stall and halt.

Parameters:
- PC_W, 10, program counter / imem address width
- INSTR_W, 9, instruction width
- LUT_IDX_W, 4, jump-LUT index width (depth = 2**LUT_IDX_W)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution at PC 0 (pulse)
- stall  in  1  downstream hold; freeze PC and current instruction
- halt_in  in  1  current instruction is a halt (from execute)
- branch_taken  in  1  current instruction's branch resolved taken
- branch_idx  in  LUT_IDX_W  jump-LUT index (decoder imm[3:0])
- lut_we  in  1  jump-LUT write enable
- lut_waddr  in  LUT_IDX_W  jump-LUT write index
- lut_wdata  in  PC_W  jump-LUT write target
- imem_addr  out  PC_W  instruction memory read address
- imem_rdata  in  INSTR_W  memory data, valid 1 cycle after address
- instr_out  out  INSTR_W  instruction to decoder (= imem_rdata)
- instr_pc  out  PC_W  PC of instr_out
- instr_valid  out  1  instr_out is live and must be executed
- done  out  1  high from halt acceptance until next start

Behaviour:
- Reset values: state IDLE, pc=0, cur_pc=0, valid_q=0, done=0, all LUT entries 0. Outputs are instr_valid=0, instr_pc=0, done=0, imem_addr=0.
- States and transitions:
  - IDLE -> RUN on start. This sets pc=0 and valid_q=0.
  - RUN -> DONE on accepted halt.
  - DONE -> RUN on start, which restarts at PC 0 and clears done.
  - start in RUN is ignored.
- Accept condition: accept = RUN && valid_q && !stall.
- imem_addr = (RUN && stall) ? cur_pc : pc. During a stall the same address is re-fetched, so instr_out stays stable.
- Each RUN cycle with stall=0: cur_pc <= pc, pc <= pc+1, valid_q <= 1.
- instr_pc = cur_pc of the previous cycle (registered alongside valid_q). instr_valid = valid_q && RUN.
- Latency: address issued in cycle n -> instruction valid in cycle n+1. First instruction is valid 2 cycles after start.
- Branch: when accept && branch_taken, the next pc = lut[branch_idx] and valid_q <= 0 for one cycle, squashing the in-flight pc+1 fetch. Penalty is exactly 1 bubble. The target instruction is valid 2 cycles after the branch cycle.
- branch_taken and halt_in are ignored when !accept (stalled, invalid, IDLE, DONE).
- Halt has priority over branch in the same cycle. pc freezes, valid_q <= 0, done <= 1.
- PC arithmetic is modulo 2**PC_W. From all-ones it wraps to 0 silently.
- LUT write is accepted in any state. A read and write of the same index in the same cycle returns the old value (new value visible next cycle).
- stall during IDLE/DONE has no effect.
- Reset mid-operation returns everything to reset values immediately (asynchronously). LUT contents are lost.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs perf_instr_cnt[15:0] and perf_bubble_cnt[15:0]:
  - perf_instr_cnt increments per accepted instruction.
  - perf_bubble_cnt increments per RUN cycle with instr_valid=0 (startup, squash).
  - Both saturate at 16'hFFFF, clear on reset and on start.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds PC_W, INSTR_W and LUT_IDX_W defaults, plus the fetch_state_t enum {IDLE, RUN, DONE}.
- Sub-module jump_lut: 2**LUT_IDX_W x PC_W register array with async-reset, 1 write port and 1 combinational read port. Read of a concurrently written entry returns old data.
- The rest (PC, state machine, valid/squash) stays in fetch_unit.

Test Plan:
- Sequential fetch: imem[i]=i, start, no stall.
  - instr_out 0,1,2,3 on cycles 2,3,4,5 after start, with instr_pc matching and instr_valid=1 throughout.
- Stall: assert stall for 3 cycles while instr_pc=5.
  - instr_out holds imem[5] and instr_pc=5 for all 3 cycles, imem_addr=5.
  - After release, the next instructions are 6 and then 7.
- Taken branch: lut[3]=0x40, branch_taken with branch_idx=3 at instr_pc=10.
  - Next cycle instr_valid=0, then instr_pc=0x40.
  - PC 11 is never valid.
  - Same-cycle write of lut[3]=0x50 still jumps to 0x40.
- Halt + branch in the same cycle at instr_pc=7: done=1, instr_valid stays 0, pc frozen.
  - start restarts at PC 0 with done=0.
- Wrap: PC_W=4, no branches. After instr_pc=15 the next valid instruction has instr_pc=0.
- Async reset mid-RUN (rst_n low between edges): outputs drop to reset values immediately.
  - After release, lut[3] reads 0 and the block idles until start.
  - With FETCH_PERF_CNT_EN, the counters read 0 and the branch test yields perf_bubble_cnt=3 (2 startup + 1 squash).
